// File: rtl/ddr_access_arbiter_pkg.sv
// Shared types and constants for the DDR AXI port arbiter.
// State encoding, requester indices and round-robin pick helper.
package ddr_arb_pkg;

  localparam logic [2:0] S_WAIT_INIT = 3'd0;
  localparam logic [2:0] S_SETTLE    = 3'd1;
  localparam logic [2:0] S_IDLE      = 3'd2;
  localparam logic [2:0] S_OWN       = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  localparam int unsigned REQ_WR = 0;
  localparam int unsigned REQ_RD = 1;

  typedef logic [1:0] req_vec_t;

  // Index to grant: the one not served last when both ask.
  function automatic logic pick(
    input req_vec_t req,
    input logic     last
  );
    return (&req) ? ~last : req[REQ_RD];
  endfunction

endpackage

// File: rtl/ddr_access_arbiter_if.sv
// Requester-side handshake bundle of the DDR AXI port arbiter.
// master = requesters, slave = arbiter.
interface ddr_access_arbiter_if;
  logic [1:0] req_i;
  logic [1:0] done_i;
  logic [1:0] gnt_o;
  logic       sel_o;

  modport master (
    output req_i,
    output done_i,
    input  gnt_o,
    input  sel_o
  );

  modport slave (
    input  req_i,
    input  done_i,
    output gnt_o,
    output sel_o
  );
endinterface

// File: rtl/ddr_arb_timer.sv
// Loadable 16-bit down-counter with zero flag.
// Shared by the settle delay and the ownership timeout.
module ddr_arb_timer (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        load,
  input  logic        dec,
  input  logic [15:0] load_val,
  output logic        zero
);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ddr_access_arbiter.sv
// Two-requester round-robin arbiter for the shared DDR AXI port.
// Waits for DDR init + settle, enforces ownership timeout and a dead cycle.
module ddr_access_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned SETTLE  = 16
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  ddr_init_done_i,
  ddr_access_arbiter_if.slave   arb,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic                  timeout_id_o
);

  localparam logic [15:0] SETTLE_LD = 16'(SETTLE - 1);
  localparam logic [15:0] TOUT_LD   = 16'(TIMEOUT - 1);

  logic [2:0]  state, state_n;
  logic [1:0]  gnt_n;
  logic        sel_n;
  logic        last, last_n;
  logic        ready_n, to_n, tid_n;
  logic        t_load, t_dec, t_zero;
  logic [15:0] t_val;
  logic        nxt;
  logic        own_done;

  assign nxt      = pick(arb.req_i, last);
  assign own_done = arb.done_i[arb.sel_o];

  ddr_arb_timer u_timer (
    .clk      (clk),
    .rstn_i   (rstn_i),
    .load     (t_load),
    .dec      (t_dec),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_comb begin
    state_n = state;
    gnt_n   = arb.gnt_o;
    sel_n   = arb.sel_o;
    last_n  = last;
    ready_n = ready_o;
    to_n    = 1'b0;
    tid_n   = timeout_id_o;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    t_val   = TOUT_LD;
    if (state != S_WAIT_INIT && !ddr_init_done_i) begin
      state_n = S_WAIT_INIT;
      gnt_n   = 2'b00;
      ready_n = 1'b0;
      t_load  = 1'b1;
      t_val   = '0;
    end else begin
      unique case (state)
        S_WAIT_INIT: begin
          if (ddr_init_done_i) begin
            t_load  = 1'b1;
            t_val   = SETTLE_LD;
            state_n = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (t_zero) begin
            state_n = S_IDLE;
            ready_n = 1'b1;
          end else begin
            t_dec = 1'b1;
          end
        end
        // GAP arbitrates like IDLE so owners are split by one dead cycle.
        S_IDLE, S_GAP: begin
          state_n = S_IDLE;
          if (|arb.req_i) begin
            gnt_n   = nxt ? 2'b10 : 2'b01;
            sel_n   = nxt;
            t_load  = 1'b1;
            t_val   = TOUT_LD;
            state_n = S_OWN;
          end
        end
        S_OWN: begin
          if (own_done) begin
            gnt_n   = 2'b00;
            last_n  = arb.sel_o;
            state_n = S_GAP;
          end else if (t_zero) begin
            gnt_n   = 2'b00;
            last_n  = arb.sel_o;
            to_n    = 1'b1;
            tid_n   = arb.sel_o;
            state_n = S_GAP;
          end else begin
            t_dec = 1'b1;
          end
        end
        default: begin
          state_n = S_WAIT_INIT;
          gnt_n   = 2'b00;
          ready_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= S_WAIT_INIT;
      arb.gnt_o    <= 2'b00;
      arb.sel_o    <= 1'b0;
      last         <= 1'b1;
      ready_o      <= 1'b0;
      busy_o       <= 1'b0;
      timeout_o    <= 1'b0;
      timeout_id_o <= 1'b0;
    end else begin
      state        <= state_n;
      arb.gnt_o    <= gnt_n;
      arb.sel_o    <= sel_n;
      last         <= last_n;
      ready_o      <= ready_n;
      busy_o       <= |gnt_n;
      timeout_o    <= to_n;
      timeout_id_o <= tid_n;
    end
  end

endmodule

// File: tb/tb_ddr_access_arbiter.sv
// Directed bench for ddr_access_arbiter (TIMEOUT=8, SETTLE=16).
// Per-cycle expectations are hand-derived from the stimulus schedule.
module tb_ddr_access_arbiter;

  logic clk = 1'b0;
  logic rstn;
  logic init;
  logic ready, busy, tout, tid;
  int   n_run  = 0;
  int   n_fail = 0;

  ddr_access_arbiter_if arb();

  ddr_access_arbiter #(
    .TIMEOUT (8),
    .SETTLE  (16)
  ) dut (
    .clk             (clk),
    .rstn_i          (rstn),
    .ddr_init_done_i (init),
    .arb             (arb.slave),
    .ready_o         (ready),
    .busy_o          (busy),
    .timeout_o       (tout),
    .timeout_id_o    (tid)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] e_gnt(input int c);
    if (c >= 28 && c <= 32) return 2'b01;
    if (c >= 34 && c <= 38) return 2'b10;
    if (c >= 40 && c <= 47) return 2'b01;
    if (c >= 49 && c <= 56) return 2'b10;
    if (c >= 58 && c <= 65) return 2'b01;
    if (c >= 68 && c <= 70) return 2'b10;
    if (c >= 91)            return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic e_rdy(input int c);
    return (c >= 27 && c <= 70) || (c >= 90);
  endfunction

  function automatic logic e_sel(input int c);
    return (c >= 34 && c <= 39) || (c >= 49 && c <= 57) || (c >= 68);
  endfunction

  function automatic logic e_to(input int c);
    return (c == 48) || (c == 57);
  endfunction

  function automatic logic e_tid(input int c);
    return (c >= 57);
  endfunction

  task automatic chk_all(input int c);
    logic [1:0] g;
    g = e_gnt(c);
    chk($sformatf("gnt@%0d", c), 16'(arb.gnt_o), 16'(g));
    chk($sformatf("busy@%0d", c), 16'(busy), 16'(|g));
    chk($sformatf("ready@%0d", c), 16'(ready), 16'(e_rdy(c)));
    chk($sformatf("sel@%0d", c), 16'(arb.sel_o), 16'(e_sel(c)));
    chk($sformatf("tout@%0d", c), 16'(tout), 16'(e_to(c)));
    chk($sformatf("tid@%0d", c), 16'(tid), 16'(e_tid(c)));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"}, 16'(arb.gnt_o), 16'd0);
    chk({tag, "_sel"}, 16'(arb.sel_o), 16'd0);
    chk({tag, "_ready"}, 16'(ready), 16'd0);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_tout"}, 16'(tout), 16'd0);
    chk({tag, "_tid"}, 16'(tid), 16'd0);
  endtask

  initial begin
    rstn       = 1'b0;
    init       = 1'b0;
    arb.req_i  = 2'b00;
    arb.done_i = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rstn = 1'b1;
    for (int c = 1; c <= 93; c++) begin
      @(posedge clk);
      #1;
      chk_all(c);
      case (c)
        10: begin init = 1'b1; arb.req_i = 2'b11; end
        30: arb.done_i = 2'b10;
        31: arb.done_i = 2'b00;
        32: arb.done_i = 2'b01;
        33: arb.done_i = 2'b00;
        38: arb.done_i = 2'b10;
        39: arb.done_i = 2'b00;
        40: arb.req_i = 2'b01;
        48: arb.req_i = 2'b10;
        57: arb.req_i = 2'b01;
        65: arb.done_i = 2'b01;
        66: begin arb.done_i = 2'b00; arb.req_i = 2'b00; end
        67: arb.req_i = 2'b10;
        70: init = 1'b0;
        73: init = 1'b1;
        default: ;
      endcase
    end
    #3;
    rstn = 1'b0;
    #1;
    chk_reset("arst");
    #2;
    rstn = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
